// File: rtl/pin_in_filter_pkg.sv
// Shared constants and types for the pad input conditioning block.
// Holds the default pin count and counter width used by the filter.
package pin_in_filter_pkg;

   localparam int PINS_DEF  = 32;
   localparam int CNT_W_DEF = 4;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } pin_state_e;

endpackage

// File: rtl/pin_in_filter_bit.sv
// One pad: two-flop synchronizer, stability counter, filtered level,
// edge pulses and a sticky edge-event flag.
module pin_in_filter_bit
   import pin_in_filter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             res,
   input  logic             pin_in,
   input  logic [CNT_W-1:0] thr,
   input  logic             evt_en,
   input  logic             evt_clr,
   output logic             pin_filt,
   output logic             rise,
   output logic             fall,
   output logic             evt
);

   logic             s1;
   logic             s2;
   logic             filt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lim_m1;
   logic [CNT_W-1:0] cnt_nxt;
   logic             tog;
   logic             evt_nxt;
   pin_state_e       state;

   // A threshold of zero behaves exactly like a threshold of one.
   assign lim_m1 = (thr == '0) ? '0 : thr - 1'b1;
   assign state  = (s2 != filt) ? ST_PENDING : ST_STABLE;

   always_comb begin
      tog     = 1'b0;
      cnt_nxt = '0;
      unique case (state)
         ST_STABLE: cnt_nxt = '0;
         ST_PENDING: begin
            if (cnt >= lim_m1) begin
               tog = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: cnt_nxt = '0;
      endcase
   end

   // A fresh edge outranks a clear arriving on the same cycle.
   always_comb begin
      evt_nxt = evt;
      if ((rise | fall) & evt_en) begin
         evt_nxt = 1'b1;
      end else if (evt_clr) begin
         evt_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         filt <= 1'b0;
         cnt  <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
         evt  <= 1'b0;
      end else begin
         s1   <= pin_in;
         s2   <= s1;
         filt <= filt ^ tog;
         cnt  <= cnt_nxt;
         rise <= tog & ~filt;
         fall <= tog & filt;
         evt  <= evt_nxt;
      end
   end

   assign pin_filt = filt;

endmodule

// File: rtl/pin_in_filter.sv
// Pad input conditioning: PINS independent synchronize-and-debounce
// lanes sharing one stability threshold.
module pin_in_filter
   import pin_in_filter_pkg::*;
#(
   parameter int PINS  = PINS_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             res,
   input  logic [PINS-1:0]  pin_in,
   input  logic [CNT_W-1:0] thr,
   input  logic [PINS-1:0]  evt_en,
   input  logic [PINS-1:0]  evt_clr,
   output logic [PINS-1:0]  pin_filt,
   output logic [PINS-1:0]  rise,
   output logic [PINS-1:0]  fall,
   output logic [PINS-1:0]  evt
);

   for (genvar i = 0; i < PINS; i++) begin : g_pin
      pin_in_filter_bit #(
         .CNT_W (CNT_W)
      ) u_bit (
         .clk      (clk),
         .res      (res),
         .pin_in   (pin_in[i]),
         .thr      (thr),
         .evt_en   (evt_en[i]),
         .evt_clr  (evt_clr[i]),
         .pin_filt (pin_filt[i]),
         .rise     (rise[i]),
         .fall     (fall[i]),
         .evt      (evt[i])
      );
   end

endmodule

// File: tb/tb_pin_in_filter.sv
// Scoreboard bench for pin_in_filter: directed scenarios followed by
// random pin activity, checked against a run-length reference model.
module tb_pin_in_filter;

   localparam int PINS  = 32;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [PINS-1:0] filt;
      logic [PINS-1:0] rise;
      logic [PINS-1:0] fall;
      logic [PINS-1:0] evt;
   } exp_t;

   logic             clk = 1'b0;
   logic             res;
   logic [PINS-1:0]  pin_in;
   logic [CNT_W-1:0] thr;
   logic [PINS-1:0]  evt_en;
   logic [PINS-1:0]  evt_clr;
   logic [PINS-1:0]  pin_filt;
   logic [PINS-1:0]  rise;
   logic [PINS-1:0]  fall;
   logic [PINS-1:0]  evt;

   pin_in_filter #(
      .PINS  (PINS),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .res      (res),
      .pin_in   (pin_in),
      .thr      (thr),
      .evt_en   (evt_en),
      .evt_clr  (evt_clr),
      .pin_filt (pin_filt),
      .rise     (rise),
      .fall     (fall),
      .evt      (evt)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Reference model: delay line of sampled levels plus, per pin, the
   // number of consecutive edges the synchronized level has disagreed
   // with the filtered one.
   logic m_d1   [PINS];
   logic m_d2   [PINS];
   logic m_filt [PINS];
   logic m_rise [PINS];
   logic m_fall [PINS];
   logic m_evt  [PINS];
   int   m_run  [PINS];

   initial begin
      for (int i = 0; i < PINS; i++) begin
         m_d1[i] = 0; m_d2[i] = 0; m_filt[i] = 0;
         m_rise[i] = 0; m_fall[i] = 0; m_evt[i] = 0; m_run[i] = 0;
      end
   end

   task automatic model_edge();
      int   need;
      int   run;
      logic toggled;
      logic old_edge;
      exp_t e;
      need = (int'(thr) < 1) ? 1 : int'(thr);
      for (int i = 0; i < PINS; i++) begin
         if (res) begin
            m_d1[i] = 0; m_d2[i] = 0; m_filt[i] = 0;
            m_rise[i] = 0; m_fall[i] = 0; m_evt[i] = 0; m_run[i] = 0;
         end else begin
            old_edge = m_rise[i] | m_fall[i];
            run      = (m_d2[i] != m_filt[i]) ? m_run[i] + 1 : 0;
            toggled  = (run >= need);
            m_run[i] = toggled ? 0 : run;
            m_d2[i]  = m_d1[i];
            m_d1[i]  = pin_in[i];
            if (toggled) m_filt[i] = ~m_filt[i];
            m_rise[i] = toggled & m_filt[i];
            m_fall[i] = toggled & ~m_filt[i];
            if (old_edge & evt_en[i]) m_evt[i] = 1;
            else if (evt_clr[i])      m_evt[i] = 0;
         end
         e.filt[i] = m_filt[i];
         e.rise[i] = m_rise[i];
         e.fall[i] = m_fall[i];
         e.evt[i]  = m_evt[i];
      end
      q.push_back(e);
   endtask

   // Inputs are held from one falling edge to the next.
   task automatic step();
      model_edge();
      @(negedge clk);
      cyc++;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic chk(input string nm, input logic [PINS-1:0] act,
                      input logic [PINS-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, req);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("pin_filt", pin_filt, e.filt);
         chk("rise", rise, e.rise);
         chk("fall", fall, e.fall);
         chk("evt", evt, e.evt);
         n_cmp++;
         if ((rise & fall) != '0) begin
            n_bad++;
            $display("FAIL rise_fall_overlap cyc=%0d got=%h want=0",
                     cyc, rise & fall);
         end
      end
   end

   initial begin
      res     = 1'b1;
      pin_in  = '0;
      thr     = 4'd3;
      evt_en  = '0;
      evt_clr = '0;
      steps(3);
      res = 1'b0;
      steps(4);

      // thr=3 single rising pin
      pin_in[0] = 1'b1;
      steps(10);

      // thr=4, three-cycle glitch must be swallowed
      thr = 4'd4;
      pin_in[5] = 1'b1;
      evt_en[5] = 1'b1;
      steps(3);
      pin_in[5] = 1'b0;
      steps(10);

      // thr=0 and thr=1 on pin 31
      thr = 4'd0;
      pin_in[31] = 1'b1;
      steps(6);
      thr = 4'd1;
      pin_in[31] = 1'b0;
      steps(6);

      // sticky event: set and clear on the same edge, then lone clear
      thr = 4'd1;
      evt_en[2] = 1'b1;
      pin_in[2] = 1'b1;
      steps(5);
      pin_in[2] = 1'b0;
      steps(3);
      evt_clr[2] = 1'b1;
      steps(1);
      evt_clr[2] = 1'b0;
      steps(3);
      evt_clr[2] = 1'b1;
      steps(1);
      evt_clr[2] = 1'b0;
      steps(3);

      // threshold drop while pending
      thr = 4'd8;
      pin_in[7] = 1'b1;
      steps(7);
      thr = 4'd2;
      steps(4);

      // reset mid-pending with every pin high
      thr = 4'd3;
      pin_in = '0;
      steps(8);
      pin_in = '1;
      evt_en = '1;
      steps(4);
      res = 1'b1;
      steps(1);
      res = 1'b0;
      steps(10);

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         pin_in  = pin_in ^ ($urandom & $urandom & $urandom);
         evt_en  = $urandom;
         evt_clr = $urandom & $urandom;
         if ($urandom_range(0, 15) == 0) thr = CNT_W'($urandom);
         res = ($urandom_range(0, 199) == 0);
         step();
      end
      res = 1'b0;
      steps(2);

      repeat (3) @(posedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got=%0d want=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
